// File: rtl/alu_seq_control.sv
// Multicycle RV64I main control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory-ready stalls with an optional wait timeout, and a sticky trap state.
module alu_seq_control #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] instr_opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       trap,
    output logic [3:0] state
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
    // DECODE   | ALUOut <= old_pc+imm, dispatch on opcode
    // EXEC     | ALU op for OP/OP_IMM/LUI/AUIPC
    // ALU_WB   | rd <= ALUOut
    // MEM_ADDR | ALUOut <= rs1+imm
    // MEM_RD   | load data read, stall on mem_ready
    // MEM_WB   | rd <= memory data
    // MEM_WR   | store data write, stall on mem_ready
    // BRANCH   | compare rs1/rs2, PC <= ALUOut if taken
    // JAL      | rd <= PC, PC <= ALUOut
    // JALR     | rd <= PC, PC <= rs1+imm
    // TRAP     | sticky fault, left only by reset
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_ALU_WB   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;

    localparam logic [CNT_W-1:0] TMO     = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       fetch;
    } ctrl_t;

    // Control word for the cycle spent in state s; registered one edge ahead.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1;
                c.src_b    = 2'b01;
                c.fetch    = 1'b1;
            end
            S_DECODE: begin
                c.src_a = 2'b01;
                c.src_b = 2'b10;
            end
            S_EXEC: begin
                case (op)
                    OPC_OP, OPC_OP_32: begin
                        c.src_a  = 2'b10;
                        c.src_b  = 2'b00;
                        c.alu_op = 2'b10;
                    end
                    OPC_OP_IMM, OPC_OP_IMM_32: begin
                        c.src_a  = 2'b10;
                        c.src_b  = 2'b10;
                        c.alu_op = 2'b10;
                    end
                    OPC_LUI: begin
                        c.src_a = 2'b11;
                        c.src_b = 2'b10;
                    end
                    OPC_AUIPC: begin
                        c.src_a = 2'b01;
                        c.src_b = 2'b10;
                    end
                    default: c = '0;
                endcase
            end
            S_ALU_WB: c.reg_write = 1'b1;
            S_MEM_ADDR: begin
                c.src_a = 2'b10;
                c.src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            S_BRANCH: begin
                c.src_a         = 2'b10;
                c.src_b         = 2'b00;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
            end
            S_JAL: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b10;
                c.pc_write   = 1'b1;
                c.pc_source  = 1'b1;
            end
            S_JALR: begin
                c.src_a      = 2'b10;
                c.src_b      = 2'b10;
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    ctrl_t            r_ctrl;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wait_state;
    logic             w_timeout;

    always_comb begin
        w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
        w_timeout    = (MEM_TIMEOUT != 0) && (r_cnt >= TMO);
        w_state_nxt  = S_TRAP;
        case (r_state)
            S_FETCH:  w_state_nxt = mem_ready ? S_DECODE : (w_timeout ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (instr_opcode)
                    OPC_LOAD, OPC_STORE:                  w_state_nxt = S_MEM_ADDR;
                    OPC_OP, OPC_OP_32, OPC_OP_IMM,
                    OPC_OP_IMM_32, OPC_LUI, OPC_AUIPC:    w_state_nxt = S_EXEC;
                    OPC_BRANCH:                           w_state_nxt = S_BRANCH;
                    OPC_JAL:                              w_state_nxt = S_JAL;
                    OPC_JALR:                             w_state_nxt = S_JALR;
                    default:                              w_state_nxt = S_TRAP;
                endcase
            end
            S_EXEC:     w_state_nxt = S_ALU_WB;
            S_ALU_WB:   w_state_nxt = S_FETCH;
            S_MEM_ADDR: w_state_nxt = (instr_opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_state_nxt = mem_ready ? S_MEM_WB : (w_timeout ? S_TRAP : S_MEM_RD);
            S_MEM_WB:   w_state_nxt = S_FETCH;
            S_MEM_WR:   w_state_nxt = mem_ready ? S_FETCH : (w_timeout ? S_TRAP : S_MEM_WR);
            S_BRANCH:   w_state_nxt = S_FETCH;
            S_JAL:      w_state_nxt = S_FETCH;
            S_JALR:     w_state_nxt = S_FETCH;
            default:    w_state_nxt = S_TRAP;
        endcase

        // Saturating stall counter, only live while parked in a memory wait.
        w_cnt_nxt = '0;
        if (w_wait_state && !mem_ready && (w_state_nxt == r_state)) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_ctrl  <= decode_ctrl(S_FETCH, 7'd0);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ctrl  <= decode_ctrl(w_state_nxt, instr_opcode);
        end
    end

    // Everything is held quiet while reset is asserted, even though FETCH is loaded.
    assign alu_op        = rst ? 2'b00 : r_ctrl.alu_op;
    assign alu_src_a     = rst ? 2'b00 : r_ctrl.src_a;
    assign alu_src_b     = rst ? 2'b00 : r_ctrl.src_b;
    assign pc_write      = !rst && (r_ctrl.pc_write || (r_ctrl.fetch && mem_ready));
    assign pc_write_cond = !rst && r_ctrl.pc_write_cond;
    assign pc_source     = !rst && r_ctrl.pc_source;
    assign i_or_d        = !rst && r_ctrl.i_or_d;
    assign mem_read      = !rst && r_ctrl.mem_read;
    assign mem_write     = !rst && r_ctrl.mem_write;
    assign ir_write      = !rst && r_ctrl.fetch && mem_ready;
    assign reg_write     = !rst && r_ctrl.reg_write;
    assign mem_to_reg    = rst ? 2'b00 : r_ctrl.mem_to_reg;
    assign trap          = !rst && (r_state == S_TRAP);
    assign state         = r_state;

endmodule

// File: tb/tb_alu_seq_control.sv
// Bench for alu_seq_control: directed literal checks plus a randomized run compared
// every cycle against an instruction-path reference model.
module tb_alu_seq_control;

    localparam int TMO = 4;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] instr_opcode = 7'd0;
    logic       mem_ready = 1'b0;

    logic [1:0] d_alu_op, d_src_a, d_src_b, d_mem_to_reg;
    logic       d_pc_write, d_pc_write_cond, d_pc_source, d_i_or_d;
    logic       d_mem_read, d_mem_write, d_ir_write, d_reg_write, d_trap;
    logic [3:0] d_state;

    alu_seq_control #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .instr_opcode(instr_opcode), .mem_ready(mem_ready),
        .alu_op(d_alu_op), .alu_src_a(d_src_a), .alu_src_b(d_src_b),
        .pc_write(d_pc_write), .pc_write_cond(d_pc_write_cond), .pc_source(d_pc_source),
        .i_or_d(d_i_or_d), .mem_read(d_mem_read), .mem_write(d_mem_write),
        .ir_write(d_ir_write), .reg_write(d_reg_write), .mem_to_reg(d_mem_to_reg),
        .trap(d_trap), .state(d_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: current state number, stall count and the states still to visit.
    int         m_state = 0;
    int         m_cnt = 0;
    logic [6:0] m_op = 7'd0;
    int         m_seq[$];

    logic [6:0] legal_ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0111011,
                                   7'b0010011, 7'b0011011, 7'b0110111, 7'b0010111,
                                   7'b1100011, 7'b1101111, 7'b1100111};

    task automatic next_from_seq();
        if (m_seq.size() > 0) m_state = m_seq.pop_front();
        else m_state = 0;
    endtask

    task automatic model_update();
        if (rst) begin
            m_state = 0; m_cnt = 0; m_seq.delete();
            return;
        end
        if (m_state == 0 || m_state == 5 || m_state == 7) begin
            if (mem_ready) begin
                m_cnt = 0;
                if (m_state == 0) m_state = 1;
                else next_from_seq();
            end else if (m_cnt >= TMO) begin
                m_cnt = 0; m_state = 15; m_seq.delete();
            end else if (m_cnt < 255) begin
                m_cnt = m_cnt + 1;
            end
        end else if (m_state == 1) begin
            m_op = instr_opcode;
            case (instr_opcode)
                7'b0000011: m_seq = '{4, 5, 6};
                7'b0100011: m_seq = '{4, 7};
                7'b0110011, 7'b0111011, 7'b0010011,
                7'b0011011, 7'b0110111, 7'b0010111: m_seq = '{2, 3};
                7'b1100011: m_seq = '{8};
                7'b1101111: m_seq = '{9};
                7'b1100111: m_seq = '{10};
                default:    m_seq = '{15};
            endcase
            next_from_seq();
        end else if (m_state != 15) begin
            next_from_seq();
        end
    endtask

    // {alu_op, src_a, src_b, pc_write, pc_write_cond, pc_source, i_or_d,
    //  mem_read, mem_write, ir_write, reg_write, mem_to_reg, trap, state}
    function automatic logic [20:0] exp_vec(input int s, input logic [6:0] op,
                                            input logic rdy, input logic r);
        logic [1:0] aop, sa, sb, m2r;
        logic pw, pwc, ps, iod, mr, mw, irw, rw, tr;
        aop = 0; sa = 0; sb = 0; m2r = 0;
        pw = 0; pwc = 0; ps = 0; iod = 0; mr = 0; mw = 0; irw = 0; rw = 0; tr = 0;
        if (!r) begin
            case (s)
                0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
                1:  begin sa = 2'b01; sb = 2'b10; end
                2:  begin
                        if (op == 7'b0110011 || op == 7'b0111011) begin sa = 2; sb = 0; aop = 2; end
                        else if (op == 7'b0010011 || op == 7'b0011011) begin sa = 2; sb = 2; aop = 2; end
                        else if (op == 7'b0110111) begin sa = 3; sb = 2; end
                        else if (op == 7'b0010111) begin sa = 1; sb = 2; end
                    end
                3:  rw = 1;
                4:  begin sa = 2; sb = 2; end
                5:  begin iod = 1; mr = 1; end
                6:  begin rw = 1; m2r = 2'b01; end
                7:  begin iod = 1; mw = 1; end
                8:  begin sa = 2; sb = 0; aop = 2'b01; pwc = 1; ps = 1; end
                9:  begin rw = 1; m2r = 2'b10; pw = 1; ps = 1; end
                10: begin sa = 2; sb = 2; pw = 1; rw = 1; m2r = 2'b10; end
                15: tr = 1;
                default: tr = 0;
            endcase
        end
        return {aop, sa, sb, pw, pwc, ps, iod, mr, mw, irw, rw, m2r, tr, 4'(s)};
    endfunction

    always @(negedge clk) begin
        logic [20:0] act, exp;
        act = {d_alu_op, d_src_a, d_src_b, d_pc_write, d_pc_write_cond, d_pc_source,
               d_i_or_d, d_mem_read, d_mem_write, d_ir_write, d_reg_write, d_mem_to_reg,
               d_trap, d_state};
        exp = exp_vec(m_state, m_op, mem_ready, rst);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, act, exp);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // One clock: model advances on the edge, then inputs for the new cycle are applied.
    task automatic step(input logic r, input logic [6:0] op, input logic rd);
        @(posedge clk);
        model_update();
        #1;
        rst = r; instr_opcode = op; mem_ready = rd;
        if (r) begin m_state = 0; m_cnt = 0; m_seq.delete(); end
        #1;
    endtask

    task automatic step_st(input logic r, input logic [6:0] op, input logic rd, input int exp_s);
        step(r, op, rd);
        chk("dut_state", int'(d_state), exp_s);
        chk("model_state", m_state, exp_s);
    endtask

    initial begin
        int tc;
        // Reset in the middle of a store wait.
        step(1, STORE, 1);
        step_st(0, STORE, 1, 0);
        step_st(0, STORE, 1, 1);
        step_st(0, STORE, 1, 4);
        step_st(0, STORE, 0, 7);
        chk("memwr_in_wr", d_mem_write, 1);
        for (int i = 0; i < 3; i++) begin
            step_st(1, STORE, 0, 0);
            chk("memwr_in_rst", d_mem_write, 0);
            chk("memrd_in_rst", d_mem_read, 0);
        end
        step_st(0, STORE, 1, 0);
        chk("memrd_after_rst", d_mem_read, 1);

        // OP register-register.
        step_st(0, OP, 1, 1);
        step_st(0, OP, 1, 2);
        chk("exec_alu_op", d_alu_op, 2);
        chk("exec_src_a", d_src_a, 2);
        chk("exec_src_b", d_src_b, 0);
        chk("exec_reg_write", d_reg_write, 0);
        step_st(0, OP, 1, 3);
        chk("aluwb_reg_write", d_reg_write, 1);
        step_st(0, OP, 1, 0);
        chk("fetch_reg_write", d_reg_write, 0);

        // LOAD with two stall cycles in MEM_RD.
        step_st(0, LOAD, 1, 1);
        step_st(0, LOAD, 1, 4);
        step_st(0, LOAD, 0, 5);
        chk("memrd_1", d_mem_read, 1);
        step_st(0, LOAD, 0, 5);
        chk("memrd_2", d_mem_read, 1);
        step_st(0, LOAD, 1, 5);
        chk("memrd_3", d_mem_read, 1);
        step_st(0, LOAD, 1, 6);
        chk("memwb_m2r", d_mem_to_reg, 1);
        chk("memwb_memrd", d_mem_read, 0);
        step_st(0, LOAD, 1, 0);

        // BRANCH then JAL.
        step_st(0, BR, 1, 1);
        step_st(0, BR, 1, 8);
        chk("br_alu_op", d_alu_op, 1);
        chk("br_pwc", d_pc_write_cond, 1);
        chk("br_pcsrc", d_pc_source, 1);
        step_st(0, JAL, 1, 0);
        step_st(0, JAL, 1, 1);
        step_st(0, JAL, 1, 9);
        chk("jal_pcw", d_pc_write, 1);
        chk("jal_rw", d_reg_write, 1);
        chk("jal_m2r", d_mem_to_reg, 2);
        step_st(0, BAD, 1, 0);

        // Illegal opcode traps and stays there.
        step_st(0, BAD, 1, 1);
        step_st(0, BAD, 1, 15);
        for (int i = 0; i < 10; i++) begin
            step_st(0, BAD, 1'($urandom_range(1)), 15);
            chk("trap_flag", d_trap, 1);
            chk("trap_en", {d_pc_write, d_pc_write_cond, d_mem_read, d_mem_write,
                            d_ir_write, d_reg_write}, 0);
        end

        // Fetch timeout, then the same with completion on the fifth cycle.
        step(1, 7'd0, 0);
        for (int i = 0; i < 5; i++) step_st(0, 7'd0, 0, 0);
        step_st(0, 7'd0, 0, 15);
        chk("tmo_trap", d_trap, 1);
        step(1, 7'd0, 0);
        for (int i = 0; i < 4; i++) step_st(0, 7'd0, 0, 0);
        step_st(0, OP, 1, 0);
        step_st(0, OP, 1, 1);
        chk("tmo_race_trap", d_trap, 0);
        step(1, 7'd0, 1);

        // Randomized run.
        tc = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            model_update();
            #1;
            tc = (m_state == 15) ? tc + 1 : 0;
            rst = (tc >= 3) || ($urandom_range(299) == 0);
            if (m_state == 0 || rst) begin
                if ($urandom_range(15) == 0) instr_opcode = 7'($urandom_range(127));
                else instr_opcode = legal_ops[$urandom_range(10)];
            end
            mem_ready = ($urandom_range(99) < ((i < 2000) ? 75 : 45));
            if (rst) begin m_state = 0; m_cnt = 0; m_seq.delete(); end
        end

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
